// File: rtl/pim_matrix_loader.sv
// Collects a row-major A-then-B element stream into two N x N operand arrays, then launches a PIM job.
// Handshake writes land one cycle later; in_ready drops from launch until result_ready is seen in WAIT.
module pim_matrix_loader #(
  parameter int WIDTH       = 16,
  parameter int MATRIX_SIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] matrix_A [MATRIX_SIZE*MATRIX_SIZE],
  output logic [WIDTH-1:0] matrix_B [MATRIX_SIZE*MATRIX_SIZE],
  output logic             start,
  input  logic             result_ready,
  output logic             busy,
  output logic             frame_err,
  output logic [7:0]       job_count
);

  localparam int ELEMS = MATRIX_SIZE * MATRIX_SIZE;
  localparam int IDXW  = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ELEMS - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, FIRE, WAIT} state_t;

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_matrix_A [ELEMS];
  logic [WIDTH-1:0] r_matrix_B [ELEMS];
  logic             r_start;
  logic             r_busy;
  logic             r_frame_err;
  logic [7:0]       r_job_count;

  logic w_in_ready;
  logic w_hs;
  logic w_idx_end;

  assign w_in_ready = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign w_hs       = in_valid && w_in_ready;
  assign w_idx_end  = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD_A;
      r_idx       <= '0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_job_count <= 8'd0;
      for (int i = 0; i < ELEMS; i++) begin
        r_matrix_A[i] <= '0;
        r_matrix_B[i] <= '0;
      end
    end else begin
      r_start     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        LOAD_A: begin
          if (w_hs) begin
            r_matrix_A[r_idx] <= in_data;
            // in_last can never be legal while A is still being filled
            if (in_last) begin
              r_frame_err <= 1'b1;
              r_idx       <= '0;
            end else if (w_idx_end) begin
              r_state <= LOAD_B;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (w_hs) begin
            r_matrix_B[r_idx] <= in_data;
            if (in_last != w_idx_end) begin
              r_frame_err <= 1'b1;
              r_state     <= LOAD_A;
              r_idx       <= '0;
            end else if (w_idx_end) begin
              // launch outputs are registered here so they appear during FIRE
              r_state     <= FIRE;
              r_idx       <= '0;
              r_start     <= 1'b1;
              r_busy      <= 1'b1;
              r_job_count <= r_job_count + 8'd1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        FIRE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (result_ready) begin
            r_state <= LOAD_A;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= LOAD_A;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign matrix_A  = r_matrix_A;
  assign matrix_B  = r_matrix_B;
  assign start     = r_start;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;
  assign job_count = r_job_count;

endmodule

// File: doc/pim_matrix_loader.md
PIM_MATRIX_LOADER -- requirements
Module: pim_matrix_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16: element width in bits.
REQ-002 SHALL have parameter MATRIX_SIZE, default 4: matrix dimension N (N x N operands).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream element valid.
REQ-006 SHALL have port in_ready  output  1  loader can accept an element.
REQ-007 SHALL have port in_data  input  WIDTH  element value, row-major, all of A then all of B.
REQ-008 SHALL have port in_last  input  1  marks final element of a frame (last B element).
REQ-009 SHALL have port matrix_A  output  array of N*N x WIDTH  assembled operand A, row-major.
REQ-010 SHALL have port matrix_B  output  array of N*N x WIDTH  assembled operand B, row-major.
REQ-011 SHALL have port start  output  1  one-cycle launch pulse to the PIM controller.
REQ-012 SHALL have port result_ready  input  1  controller completion pulse.
REQ-013 SHALL have port busy  output  1  high from start until completion is seen.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on malformed frame.
REQ-015 SHALL have port job_count  output  8  number of start pulses issued, wrapping.

Function
REQ-016 SHALL implement FSM states LOAD_A, LOAD_B, FIRE, WAIT with a single element index counter idx in 0..N*N-1.
REQ-017 SHALL define a handshake as in_valid and in_ready both high on a rising edge; only handshakes alter matrices or idx.
REQ-018 SHALL drive in_ready high in LOAD_A and LOAD_B only; low in FIRE and WAIT.
REQ-019 LOAD_A: each handshake writes matrix_A[idx] <= in_data, idx increments; handshake at idx N*N-1 moves to LOAD_B with idx 0.
REQ-020 LOAD_B: each handshake writes matrix_B[idx] <= in_data, idx increments; handshake at idx N*N-1 with in_last high moves to FIRE.
REQ-021 SHALL treat in_last high on any handshake other than the final B element, or low on the final B element, as a frame error: element still written, frame_err pulses the next cycle, state returns to LOAD_A with idx 0, no start issued.
REQ-022 FIRE: start high for exactly one cycle (the cycle after the final handshake), job_count increments (255 wraps to 0), busy rises, next state WAIT.
REQ-023 WAIT: busy high; matrix_A and matrix_B SHALL remain unchanged; result_ready high moves to LOAD_A with idx 0 and busy low next cycle.
REQ-024 SHALL ignore result_ready in every state except WAIT, including the FIRE cycle.
REQ-025 SHALL keep matrix contents from prior frames in elements not yet overwritten; no clearing between frames.
REQ-026 in_valid held in FIRE/WAIT SHALL cause no writes and no idx change; element is accepted once LOAD_A resumes.
REQ-027 start, frame_err SHALL never be high in the same cycle.

Reset
REQ-028 On rst: state LOAD_A, idx 0, all matrix_A/matrix_B elements 0, start 0, busy 0, frame_err 0, job_count 0; in_ready high the cycle after rst deasserts.
REQ-029 rst SHALL take priority over every other input in any state, including mid-frame and in WAIT; a partial frame is discarded.

Verification
REQ-030 N=4, WIDTH=16: stream A=identity, B=1..16 with in_last on element 32, in_valid continuous -> start one cycle after 32nd handshake, matrix_B[15]=16, matrix_A[5]=1, job_count=1, busy=1.
REQ-031 In WAIT hold in_valid high with in_data=0xBEEF for 10 cycles -> in_ready 0, matrices unchanged; pulse result_ready -> busy 0 and next element written to matrix_A[0].
REQ-032 in_last high on element 10 -> frame_err one cycle, no start, next well-formed 32-element frame produces start and job_count increments by 1 only.
REQ-033 in_last low on element 32 -> frame_err pulse, state LOAD_A idx 0, job_count unchanged.
REQ-034 rst asserted after 20 handshakes -> all matrices 0, idx 0; subsequent 32-element frame completes normally with start.
REQ-035 Run 256 complete frames with result_ready returned each time -> job_count returns to 0; result_ready pulse in LOAD_A/LOAD_B has no effect.
